regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we3/ad3/wd3) between two writeback requesters.
  - A: ALU/immediate results.
  - B: load/multicycle results.
- Each source gets a one-entry holding slot with a valid/ready handshake.
- Arbitration is age-ordered; writes to x0 are suppressed.
- Exports a pending-write mask that the decode/hazard logic uses to stall readers.
- Sits between the execute/memory stages and regfile; drives regfile's write port directly.

Parameters:
ADDRESS_WIDTH, 5, register index width
DATA_WIDTH, 32, register data width

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
a_valid  in  1  source A write request
a_ready  out  1  source A slot can accept
a_addr  in  ADDRESS_WIDTH  source A destination register
a_data  in  DATA_WIDTH  source A write data
b_valid  in  1  source B write request
b_ready  out  1  source B slot can accept
b_addr  in  ADDRESS_WIDTH  source B destination register
b_data  in  DATA_WIDTH  source B write data
we3  out  1  regfile write enable (registered)
ad3  out  ADDRESS_WIDTH  regfile write address (registered)
wd3  out  DATA_WIDTH  regfile write data (registered)
pend_mask  out  2**ADDRESS_WIDTH  bit i set while a write to register i is in flight
busy  out  1  any slot or output stage occupied

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: slots invalid, age bit 0, rr pointer = A, we3=0, ad3=0, wd3=0, pend_mask=0, busy=0.
  - Reset asserted mid-operation discards all buffered and staged writes; nothing is written to regfile afterwards.
- Handshake:
  - Transfer on X_valid & X_ready at posedge.
  - X_ready = ~slotX_valid | grantX. Depends on state only, never on X_valid.
  - Once X_valid is raised, addr/data hold until transfer.
- x0 suppression: a transfer with addr==0 completes (ready honoured) but the slot is not loaded. No we3 is ever produced for ad3==0.
- Slots: each holds {addr, data}. Loaded on transfer; cleared when granted, unless reloaded the same edge.
- Age tracking: one "older" bit records which slot was loaded first. Set when one slot is loaded while the other is already valid.
- Grant (combinational from slot state):
  - Only one slot valid: grant it.
  - Both valid, different load edges: grant the older.
  - Both loaded on the same edge: grant the rr pointer's slot, then toggle rr.
  - This preserves program order for same-address writes.
- Output stage:
  - Granted entry loads we3/ad3/wd3 at the next posedge.
  - we3=0 when nothing is granted; ad3/wd3 then hold their previous values.
  - Throughput: one write per cycle.
- Latency:
  - Accept at edge E0 → granted in cycle E0..E1 → we3 high in cycle after E1 → regfile writes at E2.
  - Minimum 2 cycles accept-to-architectural-write.
  - A losing slot waits 1 further cycle per competing write.
- pend_mask:
  - Bit i = OR over {slotA, slotB, output stage with we3} of (valid & addr==i). Registered to match state.
  - Bit 0 is always 0.
- busy = slotA_valid | slotB_valid | we3.
- Simultaneous events:
  - Both sources transfer in the same cycle while both slots are empty: both are loaded and the tie-break applies.
  - A slot being granted and reloaded on the same edge: the new entry is marked younger than the other valid slot.

Decomposition:
- Package regfile_ctrl_pkg holds:
  - wb_req_t struct {addr, data}.
  - Constant REG_ZERO = 0.
  - Enum src_t {SRC_A, SRC_B} for grant/rr.
- One natural sub-module, wb_slot: a one-entry holding register with valid/ready and x0 filter. Instantiated twice.
- Arbitration, output stage and pend_mask stay in the top level.

Test Plan:
- Single A write: a_valid, a_addr=5, a_data=0xDEADBEEF for 1 cycle → we3=1, ad3=5, wd3=0xDEADBEEF exactly 2 cycles after accept; pend_mask[5] high from accept until the cycle after we3 drops.
- Same-edge A/B: A(3,0x11), B(4,0x22) accepted same edge after reset → writes in order reg3 then reg4 on consecutive cycles (rr starts at A); a repeat of the same-edge case gives B first.
- Ordering: B(7,0xAA) accepted, then A(7,0xBB) one cycle later while B is still pending → we3 sequence 7/0xAA then 7/0xBB; final regfile[7]=0xBB.
- x0: A(0,0x1234) → a_ready honoured, we3 never asserts, pend_mask stays 0, busy stays 0.
- Back-pressure: A and B held valid every cycle with distinct addresses → one we3 per cycle sustained; each source sees ready at least every other cycle; no lost or duplicated writes (scoreboard check).
- Reset mid-flight: load both slots, assert rst for 1 cycle → we3=0, pend_mask=0, a_ready=b_ready=1 the cycle after; no write to either address.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the register-file writeback arbiter: request payload, source ids, x0 index.
package regfile_ctrl_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundles both writeback requester handshakes, the regfile write port and hazard status.
interface regfile_wb_arbiter_if #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32
);

  logic                        a_valid;
  logic                        a_ready;
  logic [ADDRESS_WIDTH-1:0]    a_addr;
  logic [DATA_WIDTH-1:0]       a_data;
  logic                        b_valid;
  logic                        b_ready;
  logic [ADDRESS_WIDTH-1:0]    b_addr;
  logic [DATA_WIDTH-1:0]       b_data;
  logic                        we3;
  logic [ADDRESS_WIDTH-1:0]    ad3;
  logic [DATA_WIDTH-1:0]       wd3;
  logic [2**ADDRESS_WIDTH-1:0] pend_mask;
  logic                        busy;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, we3, ad3, wd3, pend_mask, busy
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, we3, ad3, wd3, pend_mask, busy
  );

endinterface

// File: rtl/wb_slot.sv
// One-entry writeback holding slot; transfers to x0 are accepted but never stored.
module wb_slot
  import regfile_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  output logic    in_ready,
  input  wb_req_t in_req,
  input  logic    grant,
  output logic    load,
  output logic    valid,
  output wb_req_t req,
  output logic    valid_next,
  output wb_req_t req_next
);

  logic    valid_q;
  wb_req_t req_q;

  // Ready is a function of state only so the requester never sees a valid->ready path.
  assign in_ready = ~valid_q | grant;
  assign load     = in_valid & in_ready & (in_req.addr != REG_ZERO);

  always_comb begin
    valid_next = valid_q & ~grant;
    req_next   = req_q;
    if (load) begin
      valid_next = 1'b1;
      req_next   = in_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_next;
      req_q   <= req_next;
    end
  end

  assign valid = valid_q;
  assign req   = req_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Age-ordered arbiter sharing the single regfile write port between two writeback sources.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH    = DATA_W
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned NumRegs = 2 ** ADDRESS_WIDTH;

  wb_req_t a_in, b_in, a_req, b_req, a_req_next, b_req_next, granted;
  logic    a_load, b_load, a_slot_valid, b_slot_valid, a_valid_next, b_valid_next;
  logic    grant_a, grant_b, a_stay, b_stay;

  src_t older_q, older_d, rr_q, rr_d;
  logic tie_q, tie_d;

  logic                     we3_q, we3_d;
  logic [ADDRESS_WIDTH-1:0] ad3_q, ad3_d;
  logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;
  logic [NumRegs-1:0]       mask_q, mask_d;

  assign a_in = '{addr: bus.a_addr, data: bus.a_data};
  assign b_in = '{addr: bus.b_addr, data: bus.b_data};

  wb_slot u_slot_a (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (bus.a_valid),
    .in_ready   (bus.a_ready),
    .in_req     (a_in),
    .grant      (grant_a),
    .load       (a_load),
    .valid      (a_slot_valid),
    .req        (a_req),
    .valid_next (a_valid_next),
    .req_next   (a_req_next)
  );

  wb_slot u_slot_b (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (bus.b_valid),
    .in_ready   (bus.b_ready),
    .in_req     (b_in),
    .grant      (grant_b),
    .load       (b_load),
    .valid      (b_slot_valid),
    .req        (b_req),
    .valid_next (b_valid_next),
    .req_next   (b_req_next)
  );

  // Grant: lone slot wins; otherwise the older one, with rr breaking same-edge ties.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    rr_d    = rr_q;
    unique case ({a_slot_valid, b_slot_valid})
      2'b10: grant_a = 1'b1;
      2'b01: grant_b = 1'b1;
      2'b11: begin
        if (tie_q) begin
          grant_a = (rr_q == SRC_A);
          grant_b = (rr_q == SRC_B);
          rr_d    = (rr_q == SRC_A) ? SRC_B : SRC_A;
        end else begin
          grant_a = (older_q == SRC_A);
          grant_b = (older_q == SRC_B);
        end
      end
      default: ;
    endcase
  end

  // A fresh load is younger than any entry that survives this edge.
  always_comb begin
    a_stay  = a_slot_valid & ~grant_a;
    b_stay  = b_slot_valid & ~grant_b;
    older_d = older_q;
    tie_d   = tie_q;
    if (a_load && b_load) begin
      tie_d = 1'b1;
    end else if (a_load && b_stay) begin
      older_d = SRC_B;
      tie_d   = 1'b0;
    end else if (b_load && a_stay) begin
      older_d = SRC_A;
      tie_d   = 1'b0;
    end
  end

  always_comb begin
    granted = grant_b ? b_req : a_req;
    we3_d   = grant_a | grant_b;
    ad3_d   = ad3_q;
    wd3_d   = wd3_q;
    if (we3_d) begin
      ad3_d = granted.addr;
      wd3_d = granted.data;
    end
    // Built from next state so the registered mask lines up with slot and output contents.
    mask_d = '0;
    if (a_valid_next) mask_d[a_req_next.addr] = 1'b1;
    if (b_valid_next) mask_d[b_req_next.addr] = 1'b1;
    if (we3_d)        mask_d[ad3_d]           = 1'b1;
    mask_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      older_q <= SRC_A;
      rr_q    <= SRC_A;
      tie_q   <= 1'b0;
      we3_q   <= 1'b0;
      ad3_q   <= '0;
      wd3_q   <= '0;
      mask_q  <= '0;
    end else begin
      older_q <= older_d;
      rr_q    <= rr_d;
      tie_q   <= tie_d;
      we3_q   <= we3_d;
      ad3_q   <= ad3_d;
      wd3_q   <= wd3_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.we3       = we3_q;
  assign bus.ad3       = ad3_q;
  assign bus.wd3       = wd3_q;
  assign bus.pend_mask = mask_q;
  assign bus.busy      = a_slot_valid | b_slot_valid | we3_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small regfile model fed by the write port.
module tb_regfile_wb_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rf [32];
  int            wr_count = 0;

  always @(posedge clk) begin
    if (bus.we3) begin
      rf[bus.ad3] <= bus.wd3;
      wr_count    <= wr_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
  endtask

  task automatic drive_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.a_valid = 1'b1; bus.a_addr = addr; bus.a_data = data;
  endtask

  task automatic drive_b(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.b_valid = 1'b1; bus.b_addr = addr; bus.b_data = data;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.we3 !== 1'b0) begin errors++; $display("FAIL reset_we3: got %b want 0", bus.we3); end
    checks++; if (bus.ad3 !== 5'd0) begin errors++; $display("FAIL reset_ad3: got %h want 0", bus.ad3); end
    checks++; if (bus.wd3 !== 32'd0) begin errors++; $display("FAIL reset_wd3: got %h want 0", bus.wd3); end
    checks++; if (bus.pend_mask !== 32'd0) begin errors++; $display("FAIL reset_pend: got %h want 0", bus.pend_mask); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if ({bus.a_ready, bus.b_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b want 11", {bus.a_ready, bus.b_ready}); end
  endtask

  task automatic test_single_a();
    drive_a(5'd5, 32'hDEAD_BEEF);
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", bus.a_ready); end
    tick();
    idle_inputs();
    checks++; if (bus.we3 !== 1'b0) begin errors++; $display("FAIL single_we3_e0: got %b want 0", bus.we3); end
    checks++; if (bus.pend_mask !== 32'h20) begin errors++; $display("FAIL single_pend_e0: got %h want 00000020", bus.pend_mask); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_e0: got %b want 1", bus.busy); end
    tick();
    checks++; if ({bus.we3, bus.ad3, bus.wd3} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin errors++; $display("FAIL single_write: got we3=%b ad3=%0d wd3=%h want 1/5/deadbeef", bus.we3, bus.ad3, bus.wd3); end
    checks++; if (bus.pend_mask !== 32'h20) begin errors++; $display("FAIL single_pend_e1: got %h want 00000020", bus.pend_mask); end
    tick();
    checks++; if (bus.we3 !== 1'b0) begin errors++; $display("FAIL single_we3_e2: got %b want 0", bus.we3); end
    checks++; if (bus.ad3 !== 5'd5) begin errors++; $display("FAIL single_ad3_hold: got %0d want 5", bus.ad3); end
    checks++; if (bus.pend_mask !== 32'd0) begin errors++; $display("FAIL single_pend_e2: got %h want 0", bus.pend_mask); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_e2: got %b want 0", bus.busy); end
    checks++; if (rf[5] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rf5: got %h want deadbeef", rf[5]); end
  endtask

  task automatic test_same_edge();
    do_reset();
    drive_a(5'd3, 32'h11);
    drive_b(5'd4, 32'h22);
    tick();
    idle_inputs();
    checks++; if (bus.pend_mask !== 32'h18) begin errors++; $display("FAIL tie1_pend: got %h want 00000018", bus.pend_mask); end
    checks++; if ({bus.a_ready, bus.b_ready} !== 2'b10) begin errors++; $display("FAIL tie1_ready: got %b want 10", {bus.a_ready, bus.b_ready}); end
    tick();
    checks++; if ({bus.we3, bus.ad3, bus.wd3} !== {1'b1, 5'd3, 32'h11}) begin errors++; $display("FAIL tie1_first: got %b/%0d/%h want 1/3/11", bus.we3, bus.ad3, bus.wd3); end
    tick();
    checks++; if ({bus.we3, bus.ad3, bus.wd3} !== {1'b1, 5'd4, 32'h22}) begin errors++; $display("FAIL tie1_second: got %b/%0d/%h want 1/4/22", bus.we3, bus.ad3, bus.wd3); end
    tick();
    checks++; if (bus.we3 !== 1'b0) begin errors++; $display("FAIL tie1_idle: got %b want 0", bus.we3); end
    drive_a(5'd3, 32'h33);
    drive_b(5'd4, 32'h44);
    tick();
    idle_inputs();
    checks++; if ({bus.a_ready, bus.b_ready} !== 2'b01) begin errors++; $display("FAIL tie2_ready: got %b want 01", {bus.a_ready, bus.b_ready}); end
    tick();
    checks++; if ({bus.we3, bus.ad3, bus.wd3} !== {1'b1, 5'd4, 32'h44}) begin errors++; $display("FAIL tie2_first: got %b/%0d/%h want 1/4/44", bus.we3, bus.ad3, bus.wd3); end
    tick();
    checks++; if ({bus.we3, bus.ad3, bus.wd3} !== {1'b1, 5'd3, 32'h33}) begin errors++; $display("FAIL tie2_second: got %b/%0d/%h want 1/3/33", bus.we3, bus.ad3, bus.wd3); end
    tick();
  endtask

  task automatic test_ordering();
    do_reset();
    drive_b(5'd7, 32'hAA);
    tick();
    idle_inputs();
    drive_a(5'd7, 32'hBB);
    tick();
    idle_inputs();
    checks++; if ({bus.we3, bus.ad3, bus.wd3} !== {1'b1, 5'd7, 32'hAA}) begin errors++; $display("FAIL order_first: got %b/%0d/%h want 1/7/aa", bus.we3, bus.ad3, bus.wd3); end
    checks++; if (bus.pend_mask !== 32'h80) begin errors++; $display("FAIL order_pend: got %h want 00000080", bus.pend_mask); end
    tick();
    checks++; if ({bus.we3, bus.ad3, bus.wd3} !== {1'b1, 5'd7, 32'hBB}) begin errors++; $display("FAIL order_second: got %b/%0d/%h want 1/7/bb", bus.we3, bus.ad3, bus.wd3); end
    tick();
    checks++; if (rf[7] !== 32'hBB) begin errors++; $display("FAIL order_rf7: got %h want bb", rf[7]); end
  endtask

  // A granted slot reloaded on the same edge must yield to the surviving older slot.
  task automatic test_age();
    do_reset();
    drive_a(5'd1, 32'h101);
    drive_b(5'd2, 32'h202);
    tick();
    idle_inputs();
    drive_a(5'd3, 32'h303);
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL age_reload_ready: got %b want 1", bus.a_ready); end
    tick();
    idle_inputs();
    checks++; if ({bus.we3, bus.ad3, bus.wd3} !== {1'b1, 5'd1, 32'h101}) begin errors++; $display("FAIL age_w1: got %b/%0d/%h want 1/1/101", bus.we3, bus.ad3, bus.wd3); end
    tick();
    checks++; if ({bus.we3, bus.ad3, bus.wd3} !== {1'b1, 5'd2, 32'h202}) begin errors++; $display("FAIL age_w2: got %b/%0d/%h want 1/2/202", bus.we3, bus.ad3, bus.wd3); end
    tick();
    checks++; if ({bus.we3, bus.ad3, bus.wd3} !== {1'b1, 5'd3, 32'h303}) begin errors++; $display("FAIL age_w3: got %b/%0d/%h want 1/3/303", bus.we3, bus.ad3, bus.wd3); end
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    drive_a(5'd0, 32'h1234);
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b want 1", bus.a_ready); end
    tick();
    idle_inputs();
    checks++; if ({bus.we3, bus.busy} !== 2'b00) begin errors++; $display("FAIL x0_e0: got we3/busy=%b want 00", {bus.we3, bus.busy}); end
    checks++; if (bus.pend_mask !== 32'd0) begin errors++; $display("FAIL x0_pend: got %h want 0", bus.pend_mask); end
    tick();
    checks++; if ({bus.we3, bus.busy} !== 2'b00) begin errors++; $display("FAIL x0_e1: got we3/busy=%b want 00", {bus.we3, bus.busy}); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_data [32];
    bit            exp_pend [32];
    int a_n = 0, b_n = 0, a_gap = 0, b_gap = 0, max_gap = 0;
    int accepted = 0, writes = 0;
    bit a_fire, b_fire;
    do_reset();
    for (int i = 0; i < 32; i++) exp_pend[i] = 1'b0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc < 20) begin
        drive_a(5'(1 + a_n), 32'hA000_0000 | 32'(a_n));
        drive_b(5'(16 + b_n), 32'hB000_0000 | 32'(b_n));
      end else begin
        idle_inputs();
      end
      a_fire = bus.a_valid & bus.a_ready;
      b_fire = bus.b_valid & bus.b_ready;
      if (cyc < 20) begin
        a_gap = a_fire ? 0 : a_gap + 1;
        b_gap = b_fire ? 0 : b_gap + 1;
        if (a_gap > max_gap) max_gap = a_gap;
        if (b_gap > max_gap) max_gap = b_gap;
      end
      if (a_fire) begin exp_pend[bus.a_addr] = 1'b1; exp_data[bus.a_addr] = bus.a_data; end
      if (b_fire) begin exp_pend[bus.b_addr] = 1'b1; exp_data[bus.b_addr] = bus.b_data; end
      tick();
      if (a_fire) begin a_n++; accepted++; end
      if (b_fire) begin b_n++; accepted++; end
      if (bus.we3) begin
        writes++;
        checks++;
        if (!exp_pend[bus.ad3] || exp_data[bus.ad3] !== bus.wd3) begin
          errors++;
          $display("FAIL b2b_write: got ad3=%0d wd3=%h, pending=%b want data %h",
                   bus.ad3, bus.wd3, exp_pend[bus.ad3], exp_data[bus.ad3]);
        end
        exp_pend[bus.ad3] = 1'b0;
      end
    end
    checks++; if (writes !== 21) begin errors++; $display("FAIL b2b_count: got %0d writes want 21", writes); end
    checks++; if (accepted !== 21) begin errors++; $display("FAIL b2b_accepted: got %0d want 21", accepted); end
    checks++; if (max_gap > 1) begin errors++; $display("FAIL b2b_ready_gap: got %0d cycles want <=1", max_gap); end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (exp_pend[i]) begin errors++; $display("FAIL b2b_lost: reg %0d still pending, want written", i); end
    end
  endtask

  task automatic test_reset_midflight();
    int wc;
    do_reset();
    wc = wr_count;
    drive_a(5'd8, 32'h8888);
    drive_b(5'd9, 32'h9999);
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.we3 !== 1'b0) begin errors++; $display("FAIL rstmid_we3: got %b want 0", bus.we3); end
    checks++; if (bus.pend_mask !== 32'd0) begin errors++; $display("FAIL rstmid_pend: got %h want 0", bus.pend_mask); end
    checks++; if ({bus.a_ready, bus.b_ready, bus.busy} !== 3'b110) begin errors++; $display("FAIL rstmid_ready_busy: got %b want 110", {bus.a_ready, bus.b_ready, bus.busy}); end
    tick();
    tick();
    checks++; if (wr_count !== wc) begin errors++; $display("FAIL rstmid_writes: got %0d writes want %0d", wr_count, wc); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_a();
    test_same_edge();
    test_ordering();
    test_age();
    test_x0();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
